audio_level_meter: RTL and testbench
====================================

# audio_level_meter

Parametrised multi-channel sample monitor that decimates live audio samples to a human-readable refresh rate for the HEX and LEDR displays. It succeeds the fixed 2-channel, 16-bit, 5,000,000-cycle snapshot logic in the top level. It adds:
- configurable channel count, sample width and refresh period;
- per-channel absolute-peak hold with exponential decay;
- a freeze mode;
- a thermometer-coded bar output per channel.

It sits between the audio path (after audio_modifier) and the HexDriver / LED outputs.

## Interface
- CHANNELS, 2, number of independent audio channels (≥1)
- SAMPLE_W, 16, two's-complement sample width (≥4)
- PERIOD, 5000000, display refresh period in iCLK cycles (≥2)
- DECAY_SHIFT, 4, peak-mode decay: display loses disp>>DECAY_SHIFT per refresh (1..SAMPLE_W-1)
- BAR_W, 8, bar segments per channel; power of two, ≤2^(SAMPLE_W-1)
- iCLK  in  1  system clock (CLOCK_50 domain); the block has one clock, and all logic runs on its rising edge
- iRST  in  1  reset; asynchronous and active-high
- iSample  in  CHANNELS*SAMPLE_W  channel c occupies [c*SAMPLE_W +: SAMPLE_W]; already synchronised to iCLK
- iValid  in  CHANNELS  one-cycle strobe per channel; iSample for that channel is valid while its strobe is high
- iMode  in  2  00 = raw snapshot, 01 = peak hold, 10 = freeze, 11 = treated as 00
- oDisp  out  CHANNELS*SAMPLE_W  displayed value per channel, same packing as iSample
- oBar  out  CHANNELS*BAR_W  thermometer level per channel; bit 0 is the lowest segment
- oUpdate  out  1  one-cycle pulse when oDisp refreshed

## Operation
- Period counter
  - Counts 0..PERIOD-1 and wraps.
  - The terminal cycle is counter == PERIOD-1.
  - The mode is sampled only on the terminal cycle (mode_q); iMode changes mid-period have no effect until then.
- Per-channel capture registers are updated every cycle that iValid[c] is high:
  - last[c] <= iSample[c].
  - acc[c] <= max(acc[c], abs(iSample[c])).
- abs() rules:
  - abs(x) = -x for negative x.
  - abs(most-negative) saturates to 2^(SAMPLE_W-1)-1. Example at 16 bits: abs(0x8000) = 0x7FFF.
- Refresh, on the terminal cycle, selected by the mode in effect (the new iMode):
  - Raw: oDisp[c] <= last[c], or iSample[c] if iValid[c] is high that same cycle (bypass).
  - Peak: compute dec = oDisp[c] - (oDisp[c] >> DECAY_SHIFT), with oDisp treated as unsigned magnitude. Then oDisp[c] <= max(dec, acc_eff). Here acc_eff includes a same-cycle valid sample.
  - Freeze: oDisp is held and oUpdate is not pulsed.
- Peak accumulator handling:
  - acc[c] clears to 0 on every terminal cycle. A valid sample on the terminal cycle is counted into the closing window only.
  - Entering peak mode from another mode loads oDisp from acc_eff without decay.
- Bar, computed from oDisp[c]:
  - mag = abs(oDisp[c]).
  - level = mag >> (SAMPLE_W-1-log2(BAR_W)), giving 0..BAR_W-1.
  - oBar bit i = (mag != 0) && (i <= level).
- Reset (iRST high, asynchronous):
  - counter, last, acc, oDisp, oBar, oUpdate and mode_q all go to 0 immediately.
  - After reset deasserts, counting restarts from 0.
  - A reset mid-period discards the partial window.

## Timing
- oDisp and oUpdate change on the rising edge that ends the terminal cycle. oUpdate is high for exactly one cycle following that edge.
- oBar is registered from oDisp and lags it by exactly 1 cycle.
- First refresh after reset: oUpdate rises PERIOD cycles after the first rising edge with iRST low.
- Sample-to-display latency is 1 cycle in the best case (valid on the terminal cycle) and PERIOD cycles in the worst case.
- iValid strobes on any channels in any combination, including all channels simultaneously on the terminal cycle, need no back-pressure and cause no loss.

## Test plan
Bench parameters: PERIOD=8, SAMPLE_W=16, BAR_W=8, DECAY_SHIFT=4.
- Reset value and first pulse:
  - Stimulus: assert iRST asynchronously mid-cycle.
  - Required: all outputs read 0 before the next edge.
  - Stimulus: release iRST.
  - Required: oUpdate first pulses on cycle 8, with oDisp = 0 and oBar = 0.
- Raw mode:
  - Stimulus: ch0 samples 0x1234 at cycle 2 and 0x0ABC at cycle 7 (the terminal cycle).
  - Required: oDisp ch0 = 0x0ABC at the pulse; oBar ch0 = 0x01 one cycle later.
- Peak saturation:
  - Stimulus: peak mode, ch1 sample 0x8000.
  - Required: oDisp ch1 = 0x7FFF; oBar ch1 = 0xFF.
- Peak decay:
  - Stimulus: oDisp = 0x4000 in peak mode, no further samples.
  - Required: successive refreshes give 0x3C00, then 0x3840; oBar goes 0x1F → 0x0F → 0x0F.
  - Stimulus: a sample of 0x5000 then arrives.
  - Required: the next refresh gives 0x5000.
- Freeze, then resume:
  - Stimulus: freeze mode, samples continue.
  - Required: oDisp is unchanged and oUpdate stays low for 3 periods.
  - Stimulus: switch to raw.
  - Required: the next terminal cycle loads the latest sample.
- Mid-period reset:
  - Stimulus: peak mode, acc = 0x6000 at cycle 5; iRST pulse at cycle 6.
  - Required: the next refresh shows 0 and the pulse arrives 8 cycles after release.

Source files
------------

// File: rtl/audio_level_meter.sv
// audio_level_meter
// Multi-channel sample monitor that decimates live audio samples to a slow
// refresh rate for the HEX and LEDR displays. Each channel keeps its last
// sample and the peak magnitude seen during the current refresh window. Once
// per PERIOD cycles the displayed value is refreshed from one of these, picked
// by the mode: raw snapshot, peak hold with exponential decay, or freeze.
// Ports:
//   iCLK     system clock, rising edge
//   iRST     asynchronous active-high reset
//   iSample  CHANNELS packed two's-complement samples, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   iValid   per-channel one-cycle sample strobe
//   iMode    00 raw, 01 peak hold, 10 freeze, 11 behaves as raw
//   oDisp    displayed value per channel, same packing as iSample
//   oBar     thermometer bar per channel, bit 0 lowest segment, one cycle behind oDisp
//   oUpdate  one-cycle pulse after oDisp has been refreshed
module audio_level_meter #(
  parameter int CHANNELS    = 2,
  parameter int SAMPLE_W    = 16,
  parameter int PERIOD      = 5000000,
  parameter int DECAY_SHIFT = 4,
  parameter int BAR_W       = 8
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic [CHANNELS*SAMPLE_W-1:0] iSample,
  input  logic [CHANNELS-1:0]          iValid,
  input  logic [1:0]                   iMode,
  output logic [CHANNELS*SAMPLE_W-1:0] oDisp,
  output logic [CHANNELS*BAR_W-1:0]    oBar,
  output logic                         oUpdate
);

  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  // Shift that maps a magnitude onto 0..BAR_W-1 bar levels.
  localparam int BAR_SH = SAMPLE_W - 1 - $clog2(BAR_W);

  localparam logic [1:0] MODE_RAW    = 2'b00;
  localparam logic [1:0] MODE_PEAK   = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;

  localparam logic [SAMPLE_W-1:0] ZERO_W  = {SAMPLE_W{1'b0}};
  localparam logic [SAMPLE_W-1:0] ONE_W   = {{(SAMPLE_W-1){1'b0}}, 1'b1};
  localparam logic [SAMPLE_W-1:0] MIN_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MAX_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

  // Magnitude of a two's-complement value; the most negative code saturates
  // to the largest positive code, so the result always fits SAMPLE_W-1 bits.
  function automatic logic [SAMPLE_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] r;
    if (x == MIN_NEG) begin
      r = MAX_POS;
    end else if (x[SAMPLE_W-1]) begin
      r = ~x + ONE_W;
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Thermometer bar: segments 0..level lit, nothing lit for silence.
  function automatic logic [BAR_W-1:0] bar_of(input logic [SAMPLE_W-1:0] d);
    logic [SAMPLE_W-1:0] mag;
    logic [SAMPLE_W-1:0] lvl;
    logic [BAR_W-1:0]    b;
    mag = sat_abs(d);
    lvl = mag >> BAR_SH;
    for (int i = 0; i < BAR_W; i++) begin
      b[i] = (mag != ZERO_W) && (lvl >= SAMPLE_W'(i));
    end
    return b;
  endfunction

  logic [CNT_W-1:0]    cnt_r;
  logic [1:0]          mode_q_r;
  logic                update_r;
  logic [SAMPLE_W-1:0] last_r    [CHANNELS];
  logic [SAMPLE_W-1:0] acc_r     [CHANNELS];
  logic [SAMPLE_W-1:0] disp_r    [CHANNELS];
  logic [BAR_W-1:0]    bar_r     [CHANNELS];

  logic                term_s;
  logic [1:0]          mode_eff_s;
  logic [SAMPLE_W-1:0] smp_s      [CHANNELS];
  logic [SAMPLE_W-1:0] smp_abs_s  [CHANNELS];
  logic [SAMPLE_W-1:0] acc_eff_s  [CHANNELS];
  logic [SAMPLE_W-1:0] dec_s      [CHANNELS];
  logic [SAMPLE_W-1:0] disp_nxt_s [CHANNELS];

  // Terminal-cycle detect and mode normalisation (11 behaves as raw).
  always_comb begin
    term_s     = (cnt_r == CNT_W'(PERIOD - 1));
    mode_eff_s = (iMode == 2'b11) ? MODE_RAW : iMode;
  end

  // Per-channel refresh value; acc_eff folds in a sample arriving this cycle.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      smp_s[c]     = iSample[c*SAMPLE_W +: SAMPLE_W];
      smp_abs_s[c] = sat_abs(smp_s[c]);
      if (iValid[c] && (smp_abs_s[c] > acc_r[c])) begin
        acc_eff_s[c] = smp_abs_s[c];
      end else begin
        acc_eff_s[c] = acc_r[c];
      end
      dec_s[c]      = disp_r[c] - (disp_r[c] >> DECAY_SHIFT);
      disp_nxt_s[c] = disp_r[c];
      case (mode_eff_s)
        MODE_RAW: begin
          if (iValid[c]) begin
            disp_nxt_s[c] = smp_s[c];
          end else begin
            disp_nxt_s[c] = last_r[c];
          end
        end
        MODE_PEAK: begin
          // On entry to peak mode the old display may be a signed raw value,
          // so it is replaced outright instead of being decayed.
          if (mode_q_r != MODE_PEAK) begin
            disp_nxt_s[c] = acc_eff_s[c];
          end else if (dec_s[c] > acc_eff_s[c]) begin
            disp_nxt_s[c] = dec_s[c];
          end else begin
            disp_nxt_s[c] = acc_eff_s[c];
          end
        end
        MODE_FREEZE: begin
          disp_nxt_s[c] = disp_r[c];
        end
        default: begin
          disp_nxt_s[c] = disp_r[c];
        end
      endcase
    end
  end

  // Period counter, mode latch and refresh pulse.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_r    <= {CNT_W{1'b0}};
      mode_q_r <= MODE_RAW;
      update_r <= 1'b0;
    end else begin
      if (term_s) begin
        cnt_r    <= {CNT_W{1'b0}};
        mode_q_r <= mode_eff_s;
      end else begin
        cnt_r    <= cnt_r + CNT_W'(1);
      end
      update_r <= term_s && (mode_eff_s != MODE_FREEZE);
    end
  end

  // Per-channel capture, window peak, display and bar registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int c = 0; c < CHANNELS; c++) begin
        last_r[c] <= ZERO_W;
        acc_r[c]  <= ZERO_W;
        disp_r[c] <= ZERO_W;
        bar_r[c]  <= {BAR_W{1'b0}};
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (iValid[c]) begin
          last_r[c] <= smp_s[c];
        end
        // A sample on the terminal cycle belongs only to the closing window.
        if (term_s) begin
          acc_r[c]  <= ZERO_W;
          disp_r[c] <= disp_nxt_s[c];
        end else begin
          acc_r[c]  <= acc_eff_s[c];
        end
        bar_r[c] <= bar_of(disp_r[c]);
      end
    end
  end

  // Pack per-channel registers onto the output buses.
  always_comb begin
    oDisp   = {(CHANNELS*SAMPLE_W){1'b0}};
    oBar    = {(CHANNELS*BAR_W){1'b0}};
    oUpdate = update_r;
    for (int c = 0; c < CHANNELS; c++) begin
      oDisp[c*SAMPLE_W +: SAMPLE_W] = disp_r[c];
      oBar[c*BAR_W +: BAR_W]        = bar_r[c];
    end
  end

endmodule

// File: tb/tb_audio_level_meter.sv
// Testbench for audio_level_meter: directed stimulus, a behavioural model
// that is compared every cycle, and hand-computed literal expectations.
module tb_audio_level_meter;

  localparam int CH  = 2;
  localparam int SW  = 16;
  localparam int PER = 8;
  localparam int DS  = 4;
  localparam int BW  = 8;

  logic             iCLK = 1'b0;
  logic             iRST = 1'b0;
  logic [CH*SW-1:0] iSample = '0;
  logic [CH-1:0]    iValid = '0;
  logic [1:0]       iMode = 2'b00;
  logic [CH*SW-1:0] oDisp;
  logic [CH*BW-1:0] oBar;
  logic             oUpdate;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model state.
  int          m_cnt;
  logic [1:0]  m_mode_q;
  logic        m_upd;
  logic [15:0] m_last [CH];
  logic [15:0] m_disp [CH];
  logic [7:0]  m_bar  [CH];
  int          win_q  [CH][$];

  audio_level_meter #(
    .CHANNELS(CH), .SAMPLE_W(SW), .PERIOD(PER), .DECAY_SHIFT(DS), .BAR_W(BW)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iSample(iSample), .iValid(iValid),
    .iMode(iMode), .oDisp(oDisp), .oBar(oBar), .oUpdate(oUpdate)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int abs_sat(input logic [15:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // Level = magnitude in 1/8ths of full scale; segments 0..level lit.
  function automatic logic [7:0] bar_model(input logic [15:0] d);
    int m;
    int lvl;
    m = abs_sat(d);
    if (m == 0) return 8'h00;
    lvl = m / 4096;
    return 8'((1 << (lvl + 1)) - 1);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_mode_q = 2'b00;
    m_upd = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_last[c] = 16'h0000;
      m_disp[c] = 16'h0000;
      m_bar[c]  = 8'h00;
      win_q[c].delete();
    end
  endtask

  // Advance the model across one rising edge using the inputs being driven.
  task automatic model_edge();
    bit          term;
    logic [1:0]  me;
    logic [15:0] s;
    int          peak;
    int          d;
    int          dec;
    term = (m_cnt == PER - 1);
    me = (iMode == 2'b11) ? 2'b00 : iMode;
    for (int c = 0; c < CH; c++) begin
      s = iSample[c*SW +: SW];
      m_bar[c] = bar_model(m_disp[c]);
      if (term) begin
        peak = 0;
        for (int k = 0; k < win_q[c].size(); k++)
          if (win_q[c][k] > peak) peak = win_q[c][k];
        if (iValid[c] && abs_sat(s) > peak) peak = abs_sat(s);
        case (me)
          2'b00: m_disp[c] = iValid[c] ? s : m_last[c];
          2'b01: begin
            if (m_mode_q != 2'b01) begin
              m_disp[c] = 16'(peak);
            end else begin
              d = int'(m_disp[c]);
              dec = d - d / 16;
              m_disp[c] = 16'((dec > peak) ? dec : peak);
            end
          end
          default: ;
        endcase
        win_q[c].delete();
      end else if (iValid[c]) begin
        win_q[c].push_back(abs_sat(s));
      end
      if (iValid[c]) m_last[c] = s;
    end
    m_upd = term && (me != 2'b10);
    if (term) m_mode_q = me;
    m_cnt = term ? 0 : m_cnt + 1;
  endtask

  // Compare process: every output against the model on every falling edge.
  always @(negedge iCLK) begin
    if (chk_en) begin
      chk("oUpdate", {31'd0, oUpdate}, {31'd0, m_upd});
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("oDisp[%0d]", c), {16'd0, oDisp[c*SW +: SW]}, {16'd0, m_disp[c]});
        chk($sformatf("oBar[%0d]", c), {24'd0, oBar[c*BW +: BW]}, {24'd0, m_bar[c]});
      end
    end
  end

  // One clock cycle: drive inputs at the falling edge, model at the rising edge.
  task automatic step(input logic [1:0] mode, input logic [1:0] vld,
                      input logic [15:0] s0, input logic [15:0] s1);
    iMode = mode;
    iValid = vld;
    iSample = {s1, s0};
    @(posedge iCLK);
    model_edge();
    @(negedge iCLK);
  endtask

  // Cycles from..to of a period; ch0 may strobe at p0a/p0b, ch1 at p1 (-1 = none).
  task automatic run_cycles(input logic [1:0] mode, input int from, input int to,
                            input int p0a, input logic [15:0] v0a,
                            input int p0b, input logic [15:0] v0b,
                            input int p1,  input logic [15:0] v1);
    logic [1:0]  vld;
    logic [15:0] s0;
    logic [15:0] s1;
    for (int i = from; i <= to; i++) begin
      vld = 2'b00;
      s0 = 16'h0000;
      s1 = 16'h0000;
      if (i == p0a) begin vld[0] = 1'b1; s0 = v0a; end
      if (i == p0b) begin vld[0] = 1'b1; s0 = v0b; end
      if (i == p1)  begin vld[1] = 1'b1; s1 = v1;  end
      step(mode, vld, s0, s1);
    end
  endtask

  // Asynchronous reset asserted mid-cycle, released on the next falling edge.
  task automatic do_reset();
    #2;
    iRST = 1'b1;
    iValid = 2'b00;
    model_reset();
    #1;
    chk("reset_oDisp", oDisp, 32'h0);
    chk("reset_oBar", {16'd0, oBar}, 32'h0);
    chk("reset_oUpdate", {31'd0, oUpdate}, 32'h0);
    @(negedge iCLK);
    iRST = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    int first;
    model_reset();
    @(negedge iCLK);
    do_reset();

    // First refresh after reset: pulse on cycle 8 with everything at zero.
    run_cycles(2'b00, 0, 7, -1, 16'h0, -1, 16'h0, -1, 16'h0);
    chk("first_pulse", {31'd0, oUpdate}, 32'h1);
    chk("first_disp", oDisp, 32'h0);
    chk("first_bar", {16'd0, oBar}, 32'h0);

    // Raw: latest sample wins, terminal-cycle sample bypasses.
    run_cycles(2'b00, 0, 7, 2, 16'h1234, 7, 16'h0ABC, -1, 16'h0);
    chk("raw_disp0", {16'd0, oDisp[15:0]}, 32'h0ABC);

    // Peak entry with saturating magnitude on ch1.
    run_cycles(2'b01, 0, 0, -1, 16'h0, -1, 16'h0, -1, 16'h0);
    chk("raw_bar0", {24'd0, oBar[7:0]}, 32'h01);
    run_cycles(2'b01, 1, 7, -1, 16'h0, -1, 16'h0, 3, 16'h8000);
    chk("sat_disp1", {16'd0, oDisp[31:16]}, 32'h7FFF);

    // Peak decay on ch0.
    run_cycles(2'b01, 0, 0, -1, 16'h0, -1, 16'h0, -1, 16'h0);
    chk("sat_bar1", {24'd0, oBar[15:8]}, 32'hFF);
    run_cycles(2'b01, 1, 7, 4, 16'h4000, -1, 16'h0, -1, 16'h0);
    chk("peak_load0", {16'd0, oDisp[15:0]}, 32'h4000);
    run_cycles(2'b01, 0, 0, -1, 16'h0, -1, 16'h0, -1, 16'h0);
    chk("decay_bar_a", {24'd0, oBar[7:0]}, 32'h1F);
    run_cycles(2'b01, 1, 7, -1, 16'h0, -1, 16'h0, -1, 16'h0);
    chk("decay_1", {16'd0, oDisp[15:0]}, 32'h3C00);
    run_cycles(2'b01, 0, 0, -1, 16'h0, -1, 16'h0, -1, 16'h0);
    chk("decay_bar_b", {24'd0, oBar[7:0]}, 32'h0F);
    run_cycles(2'b01, 1, 7, -1, 16'h0, -1, 16'h0, -1, 16'h0);
    chk("decay_2", {16'd0, oDisp[15:0]}, 32'h3840);
    run_cycles(2'b01, 0, 0, -1, 16'h0, -1, 16'h0, -1, 16'h0);
    chk("decay_bar_c", {24'd0, oBar[7:0]}, 32'h0F);
    // Both channels strobe together on the terminal cycle.
    run_cycles(2'b01, 1, 7, 7, 16'h5000, -1, 16'h0, 7, 16'hF000);
    chk("peak_new0", {16'd0, oDisp[15:0]}, 32'h5000);

    // Freeze for three periods while samples keep arriving.
    run_cycles(2'b10, 0, 7, 1, 16'h0100, 5, 16'h0200, 3, 16'h1111);
    run_cycles(2'b10, 0, 7, 1, 16'h0300, 5, 16'h0400, 3, 16'h1111);
    run_cycles(2'b10, 0, 7, 1, 16'h0500, 6, 16'h0777, 3, 16'h1111);
    chk("freeze_hold0", {16'd0, oDisp[15:0]}, 32'h5000);
    chk("freeze_no_pulse", {31'd0, oUpdate}, 32'h0);

    // Back to raw: the latest sample from the frozen stretch shows up.
    run_cycles(2'b00, 0, 7, -1, 16'h0, -1, 16'h0, -1, 16'h0);
    chk("resume_disp0", {16'd0, oDisp[15:0]}, 32'h0777);
    chk("resume_disp1", {16'd0, oDisp[31:16]}, 32'h1111);

    // Mid-period reset discards the partial peak window.
    run_cycles(2'b01, 0, 5, 5, 16'h6000, -1, 16'h0, -1, 16'h0);
    do_reset();
    first = -1;
    for (int i = 1; i <= 12 && first < 0; i++) begin
      step(2'b01, 2'b00, 16'h0, 16'h0);
      if (oUpdate === 1'b1) first = i;
    end
    chk("reset_pulse_cycle", first, 32'd8);
    chk("reset_disp", oDisp, 32'h0);

    run_cycles(2'b01, 0, 1, -1, 16'h0, -1, 16'h0, -1, 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
